// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) doubling, column count and FSM state type.
// The S-box is a ROM table, indexed with byte 0x00 at the lowest bit index.
package aes_pkg;

   localparam int Nb = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic [0:2047] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[int'(b) * 8 +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
// Byte i of the state is bits [8*i +: 8]; column c holds bytes 4c..4c+3 (row = byte index mod 4).
module aes_round
   import aes_pkg::*;
(
   input  logic [0:127] state_in,
   input  logic [0:127] rkey,
   input  logic         is_final,
   output logic [0:127] state_out
);

   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         sb[i] = sbox(state_in[8*i +: 8]);
      end
      // Row r rotates left by r columns.
      for (int c = 0; c < Nb; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[4*c + r] = sb[4*((c + r) % Nb) + r];
         end
      end
      for (int c = 0; c < Nb; c++) begin
         mc[4*c + 0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c + 1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c + 3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      for (int i = 0; i < 16; i++) begin
         state_out[8*i +: 8] = (is_final ? sr[i] : mc[i]) ^ rkey[8*i +: 8];
      end
   end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor: one round per clock through a single shared aes_round.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module aes_cipher_iter
   import aes_pkg::*;
#(
   parameter int Nk = 4,
   parameter int Nr = Nk + 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [0:127]           plaintext,
   input  logic [0:128*(Nr+1)-1]  keys,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [0:127]           ciphertext,
   output logic                   busy
);

   localparam logic [3:0] NR_LAST = 4'(Nr);

   state_e       state_q, state_d;
   logic [0:127] state_reg_q, state_reg_d;
   logic [3:0]   rnd_q, rnd_d;
   logic [0:127] rkey;
   logic [0:127] round_out;
   logic         last_round;

   // Constant-index mux keeps every key slice in range for any Nk.
   always_comb begin
      rkey = '0;
      for (int r = 1; r <= Nr; r++) begin
         if (rnd_q == 4'(r)) rkey = keys[128*r +: 128];
      end
   end

   assign last_round = (rnd_q == NR_LAST);

   aes_round u_round (
      .state_in  (state_reg_q),
      .rkey      (rkey),
      .is_final  (last_round),
      .state_out (round_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         state_reg_q <= '0;
         rnd_q       <= '0;
      end else begin
         state_q     <= state_d;
         state_reg_q <= state_reg_d;
         rnd_q       <= rnd_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      state_reg_d = state_reg_q;
      rnd_d       = rnd_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               state_reg_d = plaintext ^ keys[0:127];
               rnd_d       = 4'd1;
               state_d     = ST_ROUND;
            end
         end
         ST_ROUND: begin
            state_reg_d = round_out;
            if (last_round) state_d = ST_DONE;
            else            rnd_d   = rnd_q + 4'd1;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign ciphertext = out_valid ? state_reg_q : '0;

endmodule
